// File: rtl/dcache_controller.sv
// Direct-mapped write-back, write-allocate data cache: 32 lines x 256 bits.
// Stalls the pipeline on a miss and handles write-back and refill with backing memory.
module dcache_controller (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         p1_req_i,
  input  logic         p1_write_i,
  input  logic [31:0]  p1_addr_i,
  input  logic [31:0]  p1_data_i,
  output logic [31:0]  p1_data_o,
  output logic         p1_stall_o,
  output logic         mem_enable_o,
  output logic         mem_write_o,
  output logic [31:0]  mem_addr_o,
  output logic [255:0] mem_data_o,
  input  logic [255:0] mem_data_i,
  input  logic         mem_ack_i
);

  localparam int unsigned LINES  = 32;
  localparam int unsigned IDX_W  = 5;
  localparam int unsigned TAG_W  = 22;
  localparam int unsigned LINE_W = 256;
  localparam int unsigned BLK_W  = TAG_W + IDX_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MISS,
    S_WRITEBACK,
    S_ALLOCATE,
    S_REFILL_DONE
  } state_e;

  state_e state_q, state_d;

  logic [LINE_W-1:0] data_q [LINES];
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [LINES-1:0]  valid_q;
  logic [LINES-1:0]  dirty_q;

  logic [BLK_W-1:0]  req_q;
  logic              mem_en_q, mem_en_d;
  logic              mem_wr_q, mem_wr_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0] mem_data_q, mem_data_d;

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic [2:0]        word;
  logic [IDX_W-1:0]  r_idx;
  logic [TAG_W-1:0]  r_tag;
  logic              hit;
  logic              in_idle;
  logic              wr_hit;
  logic              fill;
  logic              unused_addr_bits;

  assign idx     = p1_addr_i[9:5];
  assign tag     = p1_addr_i[31:10];
  assign word    = p1_addr_i[4:2];
  assign r_idx   = req_q[IDX_W-1:0];
  assign r_tag   = req_q[BLK_W-1:IDX_W];
  assign unused_addr_bits = ^p1_addr_i[1:0];

  assign hit     = p1_req_i & valid_q[idx] & (tag_q[idx] == tag);
  assign in_idle = (state_q == S_IDLE);
  assign wr_hit  = in_idle & hit & p1_write_i;
  assign fill    = (state_q == S_ALLOCATE) & mem_ack_i;

  // Pipeline-facing side is combinational so hits cost zero stall cycles.
  assign p1_data_o  = (in_idle && hit && !p1_write_i) ? data_q[idx][{word, 5'b00000} +: 32] : 32'h0;
  assign p1_stall_o = rst_i & (in_idle ? (p1_req_i & ~hit) : 1'b1);

  assign mem_enable_o = mem_en_q;
  assign mem_write_o  = mem_wr_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_data_o   = mem_data_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= S_IDLE;
      mem_en_q   <= 1'b0;
      mem_wr_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
    end else begin
      state_q    <= state_d;
      mem_en_q   <= mem_en_d;
      mem_wr_q   <= mem_wr_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
    end
  end

  // Missing block address is captured so the transaction survives p1_req_i dropping.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      req_q <= '0;
    end else if (in_idle && p1_req_i && !hit) begin
      req_q <= p1_addr_i[31:5];
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill) begin
      valid_q[r_idx] <= 1'b1;
      dirty_q[r_idx] <= 1'b0;
    end else if (wr_hit) begin
      dirty_q[idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (fill) begin
      data_q[r_idx] <= mem_data_i;
      tag_q[r_idx]  <= r_tag;
    end else if (wr_hit) begin
      data_q[idx][{word, 5'b00000} +: 32] <= p1_data_i;
    end
  end

  // Memory request fields are computed one cycle ahead and held until ack.
  always_comb begin
    state_d    = state_q;
    mem_en_d   = 1'b0;
    mem_wr_d   = 1'b0;
    mem_addr_d = '0;
    mem_data_d = '0;
    unique case (state_q)
      S_IDLE: begin
        if (p1_req_i && !hit) state_d = S_MISS;
      end
      S_MISS: begin
        mem_en_d = 1'b1;
        if (valid_q[r_idx] && dirty_q[r_idx]) begin
          state_d    = S_WRITEBACK;
          mem_wr_d   = 1'b1;
          mem_addr_d = {tag_q[r_idx], r_idx, 5'b00000};
          mem_data_d = data_q[r_idx];
        end else begin
          state_d    = S_ALLOCATE;
          mem_addr_d = {r_tag, r_idx, 5'b00000};
        end
      end
      S_WRITEBACK: begin
        mem_en_d = 1'b1;
        if (mem_ack_i) begin
          state_d    = S_ALLOCATE;
          mem_addr_d = {r_tag, r_idx, 5'b00000};
        end else begin
          mem_wr_d   = mem_wr_q;
          mem_addr_d = mem_addr_q;
          mem_data_d = mem_data_q;
        end
      end
      S_ALLOCATE: begin
        if (mem_ack_i) begin
          state_d = S_REFILL_DONE;
        end else begin
          mem_en_d   = mem_en_q;
          mem_wr_d   = mem_wr_q;
          mem_addr_d = mem_addr_q;
          mem_data_d = mem_data_q;
        end
      end
      S_REFILL_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Directed self-checking bench for dcache_controller; the bench plays the role of backing memory.
module tb_dcache_controller;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b0;
  logic         p1_req_i = 1'b0;
  logic         p1_write_i = 1'b0;
  logic [31:0]  p1_addr_i = '0;
  logic [31:0]  p1_data_i = '0;
  logic [31:0]  p1_data_o;
  logic         p1_stall_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic [255:0] mem_data_i = '0;
  logic         mem_ack_i = 1'b0;

  int total = 0;
  int bad   = 0;

  dcache_controller dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .p1_req_i     (p1_req_i),
    .p1_write_i   (p1_write_i),
    .p1_addr_i    (p1_addr_i),
    .p1_data_i    (p1_data_i),
    .p1_data_o    (p1_data_o),
    .p1_stall_o   (p1_stall_o),
    .mem_enable_o (mem_enable_o),
    .mem_write_o  (mem_write_o),
    .mem_addr_o   (mem_addr_o),
    .mem_data_o   (mem_data_o),
    .mem_data_i   (mem_data_i),
    .mem_ack_i    (mem_ack_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One CPU access; answers memory requests after `delay` wait cycles and records what was seen.
  task automatic access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input int delay, input logic [255:0] blk,
                        output int stalls, output logic [31:0] rdata,
                        output logic wb_seen, output logic [31:0] wb_addr,
                        output logic [255:0] wb_data, output logic [31:0] al_addr,
                        output logic stable, output logic drop_ok);
    int en_cnt;
    logic cap_wr;
    logic [31:0] cap_addr;
    logic [255:0] cap_data;
    logic last_fill_ack;
    logic done;
    en_cnt = 0; cap_wr = 0; cap_addr = '0; cap_data = '0;
    last_fill_ack = 0; done = 0;
    stalls = 0; rdata = '0; wb_seen = 0; wb_addr = '0; wb_data = '0; al_addr = '0;
    stable = 1; drop_ok = 1;
    @(negedge clk_i);
    p1_req_i = 1'b1; p1_write_i = wr; p1_addr_i = addr; p1_data_i = wdata; mem_ack_i = 1'b0;
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      #1;
      if (last_fill_ack && mem_enable_o) drop_ok = 0;
      last_fill_ack = 0;
      if (!p1_stall_o) begin
        rdata = p1_data_o;
        done  = 1;
      end else begin
        stalls++;
        mem_ack_i = 1'b0;
        if (mem_enable_o) begin
          if (en_cnt == 0) begin
            cap_wr = mem_write_o; cap_addr = mem_addr_o; cap_data = mem_data_o;
          end else if (cap_wr !== mem_write_o || cap_addr !== mem_addr_o || cap_data !== mem_data_o) begin
            stable = 0;
          end
          if (en_cnt == delay) begin
            mem_ack_i = 1'b1;
            if (mem_write_o) begin
              wb_seen = 1; wb_addr = mem_addr_o; wb_data = mem_data_o;
            end else begin
              al_addr = mem_addr_o; mem_data_i = blk; last_fill_ack = 1;
            end
            en_cnt = 0;
          end else begin
            en_cnt++;
          end
        end
        @(negedge clk_i);
      end
    end
    mem_ack_i = 1'b0;
    if (!done) stalls = -1;
  endtask

  initial begin
    logic [255:0] blk1, blk2, blk3, blk4, exp_wb;
    int st;
    logic [31:0] rd, wba, ala;
    logic [255:0] wbd;
    logic wbs, stb, drp;
    for (int i = 0; i < 8; i++) begin
      blk1[i*32 +: 32] = 32'h1111_0000 + 32'(i);
      blk2[i*32 +: 32] = 32'h2222_0000 + 32'(i);
      blk3[i*32 +: 32] = 32'h3333_0000 + 32'(i);
      blk4[i*32 +: 32] = 32'h4444_0000 + 32'(i);
    end
    blk1[31:0] = 32'hDEAD_BEEF;

    // Reset values
    #12;
    chk("rst_mem_enable", 256'(mem_enable_o), 256'(0));
    chk("rst_mem_write",  256'(mem_write_o),  256'(0));
    chk("rst_mem_addr",   256'(mem_addr_o),   256'(0));
    chk("rst_mem_data",   mem_data_o,         256'(0));
    chk("rst_p1_data",    256'(p1_data_o),    256'(0));
    @(negedge clk_i);
    rst_i = 1'b1;

    // Cold read miss
    access(1'b0, 32'h0000_0040, 32'h0, 0, blk1, st, rd, wbs, wba, wbd, ala, stb, drp);
    chk("cold_stall",   256'(st),  256'(4));
    chk("cold_no_wb",   256'(wbs), 256'(0));
    chk("cold_al_addr", 256'(ala), 256'(32'h40));
    chk("cold_rdata",   256'(rd),  256'(32'hDEAD_BEEF));
    chk("cold_drop",    256'(drp), 256'(1));

    // Write hit then read hits
    access(1'b1, 32'h0000_0044, 32'h1234_5678, 0, blk1, st, rd, wbs, wba, wbd, ala, stb, drp);
    chk("wrhit_stall",  256'(st), 256'(0));
    access(1'b0, 32'h0000_0044, 32'h0, 0, blk1, st, rd, wbs, wba, wbd, ala, stb, drp);
    chk("rdhit_stall",  256'(st), 256'(0));
    chk("rdhit_data",   256'(rd), 256'(32'h1234_5678));
    access(1'b0, 32'h0000_0047, 32'h0, 0, blk1, st, rd, wbs, wba, wbd, ala, stb, drp);
    chk("lowbits_data", 256'(rd), 256'(32'h1234_5678));
    access(1'b0, 32'h0000_0040, 32'h0, 0, blk1, st, rd, wbs, wba, wbd, ala, stb, drp);
    chk("word0_kept",   256'(rd), 256'(32'hDEAD_BEEF));

    // Dirty eviction of index 2
    exp_wb = blk1;
    exp_wb[63:32] = 32'h1234_5678;
    access(1'b0, 32'h0000_0440, 32'h0, 0, blk2, st, rd, wbs, wba, wbd, ala, stb, drp);
    chk("evict_stall",   256'(st),  256'(5));
    chk("evict_wb_seen", 256'(wbs), 256'(1));
    chk("evict_wb_addr", 256'(wba), 256'(32'h40));
    chk("evict_wb_data", wbd,       exp_wb);
    chk("evict_al_addr", 256'(ala), 256'(32'h440));
    chk("evict_rdata",   256'(rd),  256'(32'h2222_0000));
    chk("evict_drop",    256'(drp), 256'(1));

    // Slow memory clean miss
    access(1'b0, 32'h0000_0080, 32'h0, 6, blk3, st, rd, wbs, wba, wbd, ala, stb, drp);
    chk("slow_stall",   256'(st),  256'(10));
    chk("slow_stable",  256'(stb), 256'(1));
    chk("slow_drop",    256'(drp), 256'(1));
    chk("slow_al_addr", 256'(ala), 256'(32'h80));
    chk("slow_rdata",   256'(rd),  256'(32'h3333_0000));

    // Store miss allocates then writes
    access(1'b1, 32'h0000_0108, 32'hCAFE_F00D, 0, blk4, st, rd, wbs, wba, wbd, ala, stb, drp);
    chk("wrmiss_stall", 256'(st),  256'(4));
    chk("wrmiss_addr",  256'(ala), 256'(32'h100));
    access(1'b0, 32'h0000_0108, 32'h0, 0, blk4, st, rd, wbs, wba, wbd, ala, stb, drp);
    chk("wrmiss_read",  256'(rd),  256'(32'hCAFE_F00D));
    access(1'b0, 32'h0000_0104, 32'h0, 0, blk4, st, rd, wbs, wba, wbd, ala, stb, drp);
    chk("wrmiss_other", 256'(rd),  256'(32'h4444_0001));

    // Stray ack in idle
    @(negedge clk_i);
    p1_req_i = 1'b0; mem_ack_i = 1'b1; mem_data_i = '1;
    #1;
    chk("stray_enable", 256'(mem_enable_o), 256'(0));
    chk("stray_stall",  256'(p1_stall_o),   256'(0));
    @(negedge clk_i);
    mem_ack_i = 1'b0;
    #1;
    chk("stray_enable2", 256'(mem_enable_o), 256'(0));
    access(1'b0, 32'h0000_0440, 32'h0, 0, blk1, st, rd, wbs, wba, wbd, ala, stb, drp);
    chk("stray_hit_stall", 256'(st), 256'(0));
    chk("stray_hit_data",  256'(rd), 256'(32'h2222_0000));

    // Reset during ALLOCATE ack wait
    @(negedge clk_i);
    p1_req_i = 1'b1; p1_write_i = 1'b0; p1_addr_i = 32'hFFFF_FFE0; mem_ack_i = 1'b0;
    st = 0;
    for (int i = 0; i < 10 && !mem_enable_o; i++) begin
      @(negedge clk_i);
      #1;
      st++;
    end
    chk("rstmid_reached", 256'(mem_enable_o), 256'(1));
    chk("rstmid_addr",    256'(mem_addr_o),   256'(32'hFFFF_FFE0));
    @(negedge clk_i);
    #2;
    rst_i = 1'b0;
    #1;
    chk("rstmid_enable", 256'(mem_enable_o), 256'(0));
    chk("rstmid_stall",  256'(p1_stall_o),   256'(0));
    chk("rstmid_addr0",  256'(mem_addr_o),   256'(0));
    @(negedge clk_i);
    p1_req_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;

    // Same load misses again; index 31 / max tag behave normally
    access(1'b0, 32'hFFFF_FFE0, 32'h0, 0, blk3, st, rd, wbs, wba, wbd, ala, stb, drp);
    chk("postrst_stall", 256'(st),  256'(4));
    chk("postrst_addr",  256'(ala), 256'(32'hFFFF_FFE0));
    chk("postrst_rdata", 256'(rd),  256'(32'h3333_0000));
    access(1'b1, 32'hFFFF_FFFC, 32'hA5A5_A5A5, 0, blk3, st, rd, wbs, wba, wbd, ala, stb, drp);
    chk("idx31_wr_stall", 256'(st), 256'(0));
    access(1'b0, 32'hFFFF_FFFC, 32'h0, 0, blk3, st, rd, wbs, wba, wbd, ala, stb, drp);
    chk("idx31_rdata",    256'(rd), 256'(32'hA5A5_A5A5));
    access(1'b0, 32'h0000_0440, 32'h0, 0, blk2, st, rd, wbs, wba, wbd, ala, stb, drp);
    chk("postrst_clean_miss", 256'(st),  256'(4));
    chk("postrst_no_wb",      256'(wbs), 256'(0));

    @(negedge clk_i);
    p1_req_i = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
